// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared definitions for the next-PC stage. Holds the OP_TF
//               transfer encodings, the pc_control state encoding, the default
//               address width, and a helper that classifies OP_TF codes.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_defs;

    localparam int AW_DEFAULT = 16;

    // OP_TF encodings of the instruction currently in decode
    localparam logic [2:0] OP_JF   = 3'b000;
    localparam logic [2:0] OP_JT   = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_JR   = 3'b100;
    localparam logic [2:0] OP_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_SQUASH = 2'b10
    } pc_state_e;

    // Only the five defined transfer codes can redirect the PC; the unused
    // codes 101/110 behave exactly like OP_NONE.
    function automatic logic is_transfer(input logic [2:0] op);
        return (op == OP_JF) || (op == OP_JT) || (op == OP_J) ||
               (op == OP_JAL) || (op == OP_JR);
    endfunction

endpackage : cpu_defs
`default_nettype wire

// File: rtl/pc_control.sv
`default_nettype none
// ============================================================================
// Module      : pc_control
// Description : Next-PC stage. Takes the active-low jump decision from the
//               flag tester together with OP_TF, redirects the fetch PC,
//               squashes wrong-path slots after a taken transfer and produces
//               the jal link-register write.
// Ports       : clk, reset      - clock (rising edge), async active-high reset
//               stall           - freezes all state, masks flush/link_we
//               jump_n          - 0 = take transfer
//               op_tf           - transfer type of the decode instruction
//               dec_valid       - decode slot holds a real instruction
//               imm_target      - absolute target for jf/jt/j/jal
//               reg_target      - register target for jr
//               pc, fetch_en    - instruction memory address / read enable
//               flush           - squash instruction in fetch/decode
//               link_we         - one-cycle link register write strobe
//               link_addr       - return address (PC of jal + 1)
// Revision    : 1.0  initial release
// ============================================================================
module pc_control
    import cpu_defs::*;
#(
    parameter int            AW           = AW_DEFAULT,
    parameter logic [AW-1:0] RESET_VECTOR = '0,
    parameter int            FLUSH_CYCLES = 1      // legal range 1..3
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          jump_n,
    input  logic [2:0]    op_tf,
    input  logic          dec_valid,
    input  logic [AW-1:0] imm_target,
    input  logic [AW-1:0] reg_target,
    output logic [AW-1:0] pc,
    output logic          fetch_en,
    output logic          flush,
    output logic          link_we,
    output logic [AW-1:0] link_addr
);

    localparam logic [1:0] c_flush_init = 2'(FLUSH_CYCLES - 1);

    pc_state_e     r_state;
    pc_state_e     w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] r_dec_pc;
    logic [AW-1:0] w_dec_pc_nxt;
    logic [1:0]    r_flush_cnt;
    logic [1:0]    w_flush_cnt_nxt;
    logic          r_link_we;
    logic          w_link_we_nxt;
    logic [AW-1:0] r_link_addr;
    logic [AW-1:0] w_link_addr_nxt;
    logic          w_take;
    logic          w_flush;
    logic [AW-1:0] w_pc_inc;

    // Carry out of the incrementer is discarded: 0xFFFF wraps to 0x0000.
    assign w_pc_inc = r_pc + AW'(1);

    // ------------------------------------------------------------------------
    // State register. dec_pc starts one behind the reset vector so that the
    // "decode PC = fetch PC - 1" relation already holds in the first RUN cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VECTOR;
            r_dec_pc    <= RESET_VECTOR - AW'(1);
            r_flush_cnt <= 2'd0;
            r_link_we   <= 1'b0;
            r_link_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_dec_pc    <= w_dec_pc_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_link_we   <= w_link_we_nxt;
            r_link_addr <= w_link_addr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic. With stall high every register keeps its value
    // and no decision is taken, so the same decode inputs are re-evaluated once
    // stall drops.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_dec_pc_nxt    = r_dec_pc;
        w_flush_cnt_nxt = r_flush_cnt;
        w_link_we_nxt   = r_link_we;
        w_link_addr_nxt = r_link_addr;
        w_take          = 1'b0;
        w_flush         = 1'b0;

        if (!stall) begin
            w_link_we_nxt = 1'b0;
            case (r_state)
                ST_BOOT: begin
                    // PC stays at the reset vector; first fetch happens in RUN.
                    w_state_nxt = ST_RUN;
                end

                ST_RUN: begin
                    w_take       = dec_valid & ~jump_n & is_transfer(op_tf);
                    w_dec_pc_nxt = r_pc;
                    if (w_take) begin
                        w_flush         = 1'b1;
                        w_pc_nxt        = (op_tf == OP_JR) ? reg_target : imm_target;
                        w_flush_cnt_nxt = c_flush_init;
                        w_state_nxt     = ST_SQUASH;
                        if (op_tf == OP_JAL) begin
                            w_link_we_nxt   = 1'b1;
                            w_link_addr_nxt = r_dec_pc + AW'(1);
                        end
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end

                ST_SQUASH: begin
                    // Decode holds a wrong-path slot: its decision is ignored.
                    w_flush      = 1'b1;
                    w_dec_pc_nxt = r_pc;
                    w_pc_nxt     = w_pc_inc;
                    if (r_flush_cnt == 2'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                    end
                end

                default: begin
                    w_state_nxt = ST_BOOT;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign fetch_en  = (r_state != ST_BOOT);
    assign flush     = w_flush;
    // The strobe register holds through a stall, so the write is delayed,
    // never lost.
    assign link_we   = r_link_we & ~stall;
    assign link_addr = r_link_addr;

endmodule : pc_control
`default_nettype wire

// File: tb/tb_pc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_control
// Description : Self-checking bench for pc_control. The stimulus process
//               drives one directed vector per cycle and queues the outputs
//               expected during that cycle; a monitor process pops each entry
//               and compares it with what the DUT presents.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_control;
    import cpu_defs::*;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        stall      = 1'b0;
    logic        jump_n     = 1'b1;
    logic [2:0]  op_tf      = OP_NONE;
    logic        dec_valid  = 1'b0;
    logic [15:0] imm_target = '0;
    logic [15:0] reg_target = '0;
    logic [15:0] pc;
    logic        fetch_en;
    logic        flush;
    logic        link_we;
    logic [15:0] link_addr;

    pc_control #(
        .AW           (16),
        .RESET_VECTOR (16'h0000),
        .FLUSH_CYCLES (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .jump_n     (jump_n),
        .op_tf      (op_tf),
        .dec_valid  (dec_valid),
        .imm_target (imm_target),
        .reg_target (reg_target),
        .pc         (pc),
        .fetch_en   (fetch_en),
        .flush      (flush),
        .link_we    (link_we),
        .link_addr  (link_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        fe;
        logic        fl;
        logic        lw;
        logic [15:0] la;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
    endtask

    // Monitor: outputs are presented every cycle; sample mid-low-phase.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "pc",        pc,               e.pc);
                chk(e.nm, "fetch_en",  16'(fetch_en),    16'(e.fe));
                chk(e.nm, "flush",     16'(flush),       16'(e.fl));
                chk(e.nm, "link_we",   16'(link_we),     16'(e.lw));
                chk(e.nm, "link_addr", link_addr,        e.la);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic cyc(input logic rs, input logic st, input logic dv,
                       input logic jn, input logic [2:0] op,
                       input logic [15:0] imm, input logic [15:0] rg,
                       input logic [15:0] epc, input logic efe, input logic efl,
                       input logic elw, input logic [15:0] ela, input string nm);
        exp_t e;
        @(negedge clk);
        reset      = rs;
        stall      = st;
        dec_valid  = dv;
        jump_n     = jn;
        op_tf      = op;
        imm_target = imm;
        reg_target = rg;
        e.pc = epc; e.fe = efe; e.fl = efl; e.lw = elw; e.la = ela; e.nm = nm;
        sb.push_back(e);
    endtask

    // Plain RUN cycle with no valid decode instruction.
    task automatic idle(input logic [15:0] epc, input logic efl,
                        input logic elw, input logic [15:0] ela, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, OP_NONE, 16'h0, 16'h0, epc, 1'b1, efl, elw, ela, nm);
    endtask

    initial begin
        // Reset and boot
        cyc(1'b1, 1'b0, 1'b0, 1'b1, OP_NONE, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, "reset");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, OP_NONE, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, "boot");
        for (int i = 0; i < 16; i++) idle(16'(i), 1'b0, 1'b0, 16'h0, "count");

        // jt taken at pc=0x10; a take presented during SQUASH must be ignored
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_JT, 16'h0040, 16'h0, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0, "jt_take");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_J,  16'h0999, 16'h0, 16'h0040, 1'b1, 1'b1, 1'b0, 16'h0, "squash");
        idle(16'h0041, 1'b0, 1'b0, 16'h0, "after_squash");

        // j to 0x20 so that jal sits at decode PC 0x20
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_J, 16'h0020, 16'h0, 16'h0042, 1'b1, 1'b1, 1'b0, 16'h0, "j_take");
        idle(16'h0020, 1'b1, 1'b0, 16'h0, "j_squash");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_JAL, 16'h0100, 16'h0, 16'h0021, 1'b1, 1'b1, 1'b0, 16'h0, "jal_take");
        idle(16'h0100, 1'b1, 1'b1, 16'h0021, "jal_link");
        idle(16'h0101, 1'b0, 1'b0, 16'h0021, "jal_done");

        // jr held off by a 3-cycle stall
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, OP_JR, 16'h0, 16'h1234, 16'h0102, 1'b1, 1'b0, 1'b0, 16'h0021, "jr_stall");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_JR, 16'h0, 16'h1234, 16'h0102, 1'b1, 1'b1, 1'b0, 16'h0021, "jr_take");
        idle(16'h1234, 1'b1, 1'b0, 16'h0021, "jr_squash");

        // jal whose link strobe cycle is stalled: strobe must appear afterwards
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_JAL, 16'h0200, 16'h0, 16'h1235, 1'b1, 1'b1, 1'b0, 16'h0021, "jal2_take");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, OP_NONE, 16'h0, 16'h0, 16'h0200, 1'b1, 1'b0, 1'b0, 16'h1235, "jal2_stall");
        idle(16'h0200, 1'b1, 1'b1, 16'h1235, "jal2_link");

        // Wrap and non-taken cases
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_J, 16'hFFFE, 16'h0, 16'h0201, 1'b1, 1'b1, 1'b0, 16'h1235, "j_wrap");
        idle(16'hFFFE, 1'b1, 1'b0, 16'h1235, "wrap_squash");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_NONE, 16'h0300, 16'h0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h1235, "none_jn0");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, OP_JF,   16'h0300, 16'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1235, "jf_not");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b101,  16'h0300, 16'h0, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h1235, "unused_op");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, OP_J,    16'h0300, 16'h0, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h1235, "not_valid");

        // Reset asserted in the middle of SQUASH
        cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_J, 16'h0050, 16'h0, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h1235, "j_pre_reset");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, OP_NONE, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, "reset_mid_squash");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, OP_NONE, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, "boot2");
        idle(16'h0000, 1'b0, 1'b0, 16'h0, "run2");
        idle(16'h0001, 1'b0, 1'b0, 16'h0, "run2b");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain left %0d entries want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_pc_control
`default_nettype wire
